// File: rtl/alu_pkg.sv
// Shared ALU definitions: multiplier sequencer state encoding and sizing constants.
package alu_pkg;

  localparam int MUL_W    = 8;
  localparam int MUL_ITER = 8;
  localparam int CNT_W    = $clog2(MUL_ITER);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } mul_state_e;

endpackage : alu_pkg

// File: rtl/RCA8.sv
// 8-bit ripple-carry adder shared by the ALU datapath.
module RCA8 (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic [7:0] sum,
  output logic       cout
);

  logic [8:0] carry;

  assign carry[0] = cin;

  for (genvar i = 0; i < 8; i++) begin : g_fa
    assign sum[i]       = a[i] ^ b[i] ^ carry[i];
    assign carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
  end

  assign cout = carry[8];

endmodule : RCA8

// File: rtl/alu_mul_seq.sv
// Unsigned 8x8 shift-and-add multiplier: one RCA8 reused over 8 iterations,
// start/busy/done handshake, result and overflow flag held until the next done.
module alu_mul_seq
  import alu_pkg::*;
#(
  parameter int N = MUL_W
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [N-1:0]   A,
  input  logic [N-1:0]   B,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] Product,
  output logic           ovf
);

  if (N != MUL_W) begin : g_bad_width
    $error("alu_mul_seq: N must be %0d, the fixed RCA8 width", MUL_W);
  end

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_ITER - 1);

  mul_state_e     state, state_next;
  logic [N-1:0]   mcand;
  logic [2*N-1:0] p;
  logic [2*N-1:0] p_shift;
  logic [CNT_W-1:0] cnt;
  logic           load;
  logic           shift;
  logic [N-1:0]   add_b;
  logic [N-1:0]   add_sum;
  logic           add_cout;

  // Partial product's upper half plus the multiplicand when the current multiplier bit is set.
  assign add_b = p[0] ? mcand : '0;

  RCA8 u_rca8 (
    .a    (p[2*N-1:N]),
    .b    (add_b),
    .cin  (1'b0),
    .sum  (add_sum),
    .cout (add_cout)
  );

  assign p_shift = {add_cout, add_sum, p[N-1:1]};

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_next = state;
    load       = 1'b0;
    shift      = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          load       = 1'b1;
          state_next = S_RUN;
        end
      end
      S_RUN: begin
        busy  = 1'b1;
        shift = 1'b1;
        if (cnt == CNT_LAST) state_next = S_DONE;
      end
      S_DONE: begin
        done = 1'b1;
        if (start) begin
          load       = 1'b1;
          state_next = S_RUN;
        end else begin
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Product/ovf are written only on the last shift, so they never expose partial sums.
  always_ff @(posedge clk) begin
    if (rst) begin
      mcand   <= '0;
      p       <= '0;
      cnt     <= '0;
      Product <= '0;
      ovf     <= 1'b0;
    end else if (load) begin
      mcand <= A;
      p     <= {{N{1'b0}}, B};
      cnt   <= '0;
    end else if (shift) begin
      p   <= p_shift;
      cnt <= cnt + 1'b1;
      if (cnt == CNT_LAST) begin
        Product <= p_shift;
        ovf     <= |p_shift[2*N-1:N];
      end
    end
  end

endmodule : alu_mul_seq

// File: tb/tb_alu_mul_seq.sv
// Self-checking bench for alu_mul_seq: directed scenarios plus randomized
// operands checked against a plain a*b reference model.
module tb_alu_mul_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        busy;
  logic        done;
  logic [15:0] product;
  logic        ovf;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  alu_mul_seq #(.N(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .A       (a),
    .B       (b),
    .busy    (busy),
    .done    (done),
    .Product (product),
    .ovf     (ovf)
  );

  function automatic logic [15:0] model_prod(input logic [7:0] x, input logic [7:0] y);
    return 16'(int'(x) * int'(y));
  endfunction

  function automatic logic model_ovf(input logic [7:0] x, input logic [7:0] y);
    return (int'(x) * int'(y)) > 255;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issues one start in the current cycle (cycle 0), scrambles A/B every later
  // cycle, and returns the cycle index at which done rose (-1 if never).
  task automatic do_mul(input logic [7:0] av, input logic [7:0] bv,
                        output int lat, output logic [15:0] prod_o,
                        output logic ovf_o, output int busy_miss);
    a = av; b = bv; start = 1'b1;
    step();
    start = 1'b0;
    lat = -1; busy_miss = 0; prod_o = 'x; ovf_o = 1'bx;
    for (int c = 1; c <= 30; c++) begin
      if (done === 1'b1) begin
        lat = c; prod_o = product; ovf_o = ovf;
        break;
      end
      if (busy !== 1'b1) busy_miss++;
      a = 8'($urandom); b = 8'($urandom);
      step();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; a = 8'h00; b = 8'h00;
    repeat (3) step();
    total++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy); else passed++;
    total++; if (done !== 1'b0) $display("FAIL reset_done got=%b exp=0", done); else passed++;
    total++; if (product !== 16'h0000) $display("FAIL reset_product got=%h exp=0000", product); else passed++;
    total++; if (ovf !== 1'b0) $display("FAIL reset_ovf got=%b exp=0", ovf); else passed++;
    rst = 1'b0;
    step();
  endtask

  task automatic test_max();
    int lat, bm; logic [15:0] p; logic o;
    do_mul(8'hFF, 8'hFF, lat, p, o, bm);
    total++; if (lat != 9) $display("FAIL max_latency got=%0d exp=9", lat); else passed++;
    total++; if (bm != 0) $display("FAIL max_busy low_cycles=%0d exp=0", bm); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL max_busy_in_done got=%b exp=0", busy); else passed++;
    total++; if (p !== model_prod(8'hFF, 8'hFF)) $display("FAIL max_product got=%h exp=%h", p, model_prod(8'hFF, 8'hFF)); else passed++;
    total++; if (o !== 1'b1) $display("FAIL max_ovf got=%b exp=1", o); else passed++;
    step();
    total++; if (done !== 1'b0) $display("FAIL max_done_pulse got=%b exp=0", done); else passed++;
    total++; if (product !== 16'hFE01) $display("FAIL max_product_hold got=%h exp=fe01", product); else passed++;
  endtask

  task automatic test_small();
    int lat, bm; logic [15:0] p; logic o;
    do_mul(8'd13, 8'd11, lat, p, o, bm);
    step();
    total++; if (p !== 16'h008F || lat != 9) $display("FAIL small_13x11 got=%h@%0d exp=008f@9", p, lat); else passed++;
    total++; if (o !== 1'b0) $display("FAIL small_13x11_ovf got=%b exp=0", o); else passed++;
    do_mul(8'h00, 8'hA5, lat, p, o, bm);
    step();
    total++; if (p !== 16'h0000 || lat != 9) $display("FAIL small_0xa5 got=%h@%0d exp=0000@9", p, lat); else passed++;
    total++; if (o !== 1'b0) $display("FAIL small_0xa5_ovf got=%b exp=0", o); else passed++;
  endtask

  task automatic test_start_while_busy();
    int ndone = 0, dcyc = -1;
    logic [15:0] p = '0;
    a = 8'd3; b = 8'd5; start = 1'b1;
    step();
    for (int c = 1; c <= 20; c++) begin
      if (done === 1'b1) begin
        ndone++;
        if (dcyc < 0) begin dcyc = c; p = product; end
      end
      start = (c == 4);
      if (c == 4) begin a = 8'd7; b = 8'd7; end
      step();
    end
    start = 1'b0;
    total++; if (ndone != 1) $display("FAIL busy_start_done_count got=%0d exp=1", ndone); else passed++;
    total++; if (dcyc != 9 || p !== model_prod(8'd3, 8'd5)) $display("FAIL busy_start_result got=%h@%0d exp=%h@9", p, dcyc, model_prod(8'd3, 8'd5)); else passed++;
  endtask

  task automatic test_back_to_back();
    int lat1, lat2, bm1, bm2; logic [15:0] p1, p2; logic o1, o2;
    do_mul(8'd2, 8'd3, lat1, p1, o1, bm1);
    total++; if (busy !== 1'b0) $display("FAIL b2b_busy_gap got=%b exp=0", busy); else passed++;
    do_mul(8'd4, 8'd4, lat2, p2, o2, bm2);
    total++; if (lat1 != 9 || p1 !== 16'h0006) $display("FAIL b2b_first got=%h@%0d exp=0006@9", p1, lat1); else passed++;
    total++; if (lat2 != 9 || p2 !== 16'h0010) $display("FAIL b2b_second got=%h@%0d exp=0010@18", p2, lat1 + lat2); else passed++;
    total++; if (bm1 + bm2 != 0) $display("FAIL b2b_busy low_cycles=%0d exp=0", bm1 + bm2); else passed++;
    step();
    total++; if (busy !== 1'b0 || done !== 1'b0) $display("FAIL b2b_idle_after got=busy%b/done%b exp=0/0", busy, done); else passed++;
  endtask

  task automatic test_reset_mid_op();
    int ndone = 0, lat, bm; logic [15:0] p; logic o;
    a = 8'hFF; b = 8'h02; start = 1'b1;
    step();
    start = 1'b0;
    repeat (4) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    total++; if (busy !== 1'b0 || done !== 1'b0) $display("FAIL midrst_flags got=busy%b/done%b exp=0/0", busy, done); else passed++;
    total++; if (product !== 16'h0000 || ovf !== 1'b0) $display("FAIL midrst_outputs got=%h/%b exp=0000/0", product, ovf); else passed++;
    for (int c = 6; c <= 20; c++) begin
      if (done === 1'b1 || busy === 1'b1) ndone++;
      step();
    end
    total++; if (ndone != 0) $display("FAIL midrst_activity got=%0d cycles exp=0", ndone); else passed++;
    do_mul(8'd9, 8'd9, lat, p, o, bm);
    step();
    total++; if (p !== 16'h0051 || lat != 9) $display("FAIL midrst_restart got=%h@%0d exp=0051@9", p, lat); else passed++;
    a = 8'd1; b = 8'd1; rst = 1'b1; start = 1'b1;
    step();
    rst = 1'b0; start = 1'b0;
    ndone = 0;
    for (int c = 0; c < 12; c++) begin
      if (done === 1'b1 || busy === 1'b1) ndone++;
      step();
    end
    total++; if (ndone != 0) $display("FAIL rst_start_dropped got=%0d active cycles exp=0", ndone); else passed++;
  endtask

  task automatic test_operand_hold();
    int unstable = 0, dcyc = -1;
    logic [15:0] held, p = '0;
    held = product;
    a = 8'hB7; b = 8'h5C; start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      if (done === 1'b1 && dcyc < 0) begin dcyc = c; p = product; end
      else if (dcyc < 0 && product !== held) unstable++;
      a = ~a; b = ~b;
      step();
    end
    total++; if (unstable != 0) $display("FAIL hold_stable got=%0d changes exp=0", unstable); else passed++;
    total++; if (dcyc != 9 || p !== model_prod(8'hB7, 8'h5C)) $display("FAIL hold_result got=%h@%0d exp=%h@9", p, dcyc, model_prod(8'hB7, 8'h5C)); else passed++;
  endtask

  task automatic test_random();
    int lat, bm, bad = 0;
    logic [15:0] p; logic o;
    logic [7:0] x, y;
    for (int i = 0; i < 24; i++) begin
      x = 8'($urandom); y = 8'($urandom);
      if (i % 6 == 0) x = 8'hFF;
      if (i % 6 == 1) y = 8'h01;
      do_mul(x, y, lat, p, o, bm);
      total++;
      if (lat != 9 || bm != 0 || p !== model_prod(x, y) || o !== model_ovf(x, y)) begin
        $display("FAIL rand_%0d %h*%h got=%h ovf=%b lat=%0d exp=%h ovf=%b lat=9",
                 i, x, y, p, o, lat, model_prod(x, y), model_ovf(x, y));
        bad++;
      end else passed++;
      if ($urandom_range(1, 0) == 1) begin
        step();
        total++; if (done !== 1'b0) $display("FAIL rand_pulse_%0d done=%b exp=0", i, done); else passed++;
      end
    end
    step();
  endtask

  initial begin
    test_reset();
    test_max();
    test_small();
    test_start_while_busy();
    test_back_to_back();
    test_reset_mid_op();
    test_operand_hold();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule : tb_alu_mul_seq
